// File: rtl/rapids_pkg.sv
// Shared types for the rapids memory arbiter: read-owner encoding and the full byte mask.
package rapids_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Wide enough for data words up to 128 bits; users slice the low DATA_W/8 bits.
  localparam logic [15:0] BE_ALL = 16'hFFFF;

endpackage

// File: rtl/rapids_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data port.
// Data wins by default; a saturating starvation counter forces fetch through.
module rapids_mem_arbiter
  import rapids_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                halt,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned SW   = $clog2(MAX_STARVE + 1);

  owner_t            owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_ok;

  // reset_n is active-high: no grants are issued while it is asserted.
  assign grant_ok = !halt && !reset_n;

  always_comb begin
    d_gnt  = grant_ok && d_req && (!if_req || (starve_q < SW'(MAX_STARVE)));
    if_gnt = grant_ok && if_req && !d_gnt;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      mem_be    = BE_ALL[BE_W-1:0];
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end

    starve_d = starve_q;
    if (!halt) begin
      if (!if_req || if_gnt) begin
        starve_d = '0;
      end else if (d_gnt && (starve_q < SW'(MAX_STARVE))) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  // Read data is forwarded in the rvalid cycle and held afterwards from the capture register.
  always_comb begin
    if_rvalid  = (owner_q == OWN_IF);
    d_rvalid   = (owner_q == OWN_D);
    if_rdata_d = if_rvalid ? mem_rdata : if_rdata_q;
    d_rdata_d  = d_rvalid ? mem_rdata : d_rdata_q;
    if_rdata   = if_rdata_d;
    d_rdata    = d_rdata_d;
    busy       = (owner_q != OWN_NONE);
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      owner_q    <= OWN_NONE;
      starve_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule
